// File: rtl/iiitb_icg_pkg.sv
// Shared constants for the iiitb_icg clock-gating slice.
package iiitb_icg_pkg;

    localparam logic RST_BIT = 1'b0;

endpackage

// File: rtl/iiitb_icg_cell.sv
// Glitch-free clock gate: negative-level enable latch with async clear, ANDed with clk.
// Zero-cycle latency (enable sampled as the latch closes at clk rise); no backpressure.
module iiitb_icg_cell
    import iiitb_icg_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic gclk
);

    logic en_l;

    // Latch closes while clk is high, so en changes never shorten a gclk pulse.
    always_latch begin
        if (!rst_n) begin
            en_l <= RST_BIT;
        end else if (!clk) begin
            en_l <= en;
        end
    end

    assign gclk = clk & en_l;

endmodule

// File: rtl/iiitb_icg.sv
// Two WIDTH-bit data lanes captured on a shared gated clock derived from clk and in.
// Capture on the clk rising edge at which in was high; no backpressure, lanes hold while gated.
module iiitb_icg
    import iiitb_icg_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1
);

    logic             gclk;
    logic [WIDTH-1:0] q0_q, q0_d;
    logic [WIDTH-1:0] q1_q, q1_d;

    iiitb_icg_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in),
        .gclk  (gclk)
    );

    assign q0_d = d0;
    assign q1_d = d1;

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            q0_q <= {WIDTH{RST_BIT}};
            q1_q <= {WIDTH{RST_BIT}};
        end else begin
            q0_q <= q0_d;
            q1_q <= q1_d;
        end
    end

    assign q0 = q0_q;
    assign q1 = q1_q;

endmodule

// File: tb/tb_iiitb_icg.sv
// Directed bench for iiitb_icg: scoreboard of expected lane values plus gclk pulse monitoring.
module tb_iiitb_icg;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_r;
    logic [W-1:0] d0, d1;
    logic [W-1:0] q0, q1;

    int  n_asserts = 0;
    int  n_fail    = 0;
    int  gclk_rises = 0;
    time rise_t     = 0;
    time min_w      = 1000;

    logic [W-1:0]   m_q0 = '0;
    logic [W-1:0]   m_q1 = '0;
    logic [2*W-1:0] sb[$];

    iiitb_icg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_r),
        .d0    (d0),
        .d1    (d1),
        .q0    (q0),
        .q1    (q1)
    );

    initial begin
        clk = 1'b0;
        forever #30 clk = ~clk;
    end

    always @(posedge dut.gclk) begin
        gclk_rises++;
        rise_t = $time;
    end

    always @(negedge dut.gclk) begin
        if (($time - rise_t) < min_w) min_w = $time - rise_t;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_q();
        sb.push_back({m_q0, m_q1});
    endtask

    task automatic pop_check(input string tag);
        logic [2*W-1:0] e;
        if (sb.size() == 0) begin
            n_asserts++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %0h/%0h expected an entry", tag, q0, q1);
        end else begin
            e = sb.pop_front();
            check({tag, "_q0"}, 32'(q0), 32'(e[2*W-1:W]));
            check({tag, "_q1"}, 32'(q1), 32'(e[W-1:0]));
        end
    endtask

    // One clk cycle: drive during the low phase, score the rising edge.
    task automatic cycle(input logic en_v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag);
        @(negedge clk);
        #5;
        in_r = en_v;
        d0   = a;
        d1   = b;
        @(posedge clk);
        if (en_v && rst_n) begin
            m_q0 = a;
            m_q1 = b;
        end
        expect_q();
        #1;
        pop_check(tag);
    endtask

    initial begin
        int r0;
        int exp_pulses;

        // Reset held with data and enable high
        rst_n = 1'b0;
        in_r  = 1'b1;
        d0    = '1;
        d1    = '1;
        #1;
        gclk_rises = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_gclk", 32'(dut.gclk), 32'd0);
            check("rst_q0", 32'(q0), 32'd0);
            check("rst_q1", 32'(q1), 32'd0);
        end
        check("rst_no_pulses", gclk_rises, 0);
        @(negedge clk);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        m_q0 = d0;
        m_q1 = d1;
        expect_q();
        #1;
        pop_check("rst_release");

        // Enable held high, data toggling off-grid
        @(negedge clk);
        in_r = 1'b1;
        d0   = 4'h0;
        d1   = 4'h1;
        fork
            begin
                #5;
                repeat (15) begin
                    d0 = ~d0;
                    #40;
                end
            end
            begin
                #5;
                repeat (12) begin
                    d1 = d1 + 4'd3;
                    #50;
                end
            end
            begin
                repeat (10) begin
                    @(posedge clk);
                    m_q0 = d0;
                    m_q1 = d1;
                    expect_q();
                    #1;
                    pop_check("en_high");
                end
            end
        join

        // Enable held low: outputs frozen at F/0
        cycle(1'b1, 4'hF, 4'h0, "preload");
        r0 = gclk_rises;
        repeat (10) cycle(1'b0, W'($urandom), W'($urandom), "en_low");
        check("en_low_no_pulses", gclk_rises, r0);

        // Enable toggling every 20 ns, including mid-high-phase
        @(negedge clk);
        min_w      = 1000;
        r0         = gclk_rises;
        exp_pulses = 0;
        in_r       = 1'b0;
        fork
            begin
                #5;
                in_r = ~in_r;
                repeat (26) begin
                    #20;
                    in_r = ~in_r;
                end
            end
        join_none
        for (int k = 0; k < 9; k++) begin
            #10;
            d0 = W'(k);
            d1 = ~W'(k);
            @(posedge clk);
            if (in_r) begin
                m_q0 = d0;
                m_q1 = d1;
                exp_pulses++;
            end
            expect_q();
            #1;
            pop_check("en_toggle");
            @(negedge clk);
        end
        #1;
        in_r = 1'b0;
        check("toggle_pulse_count", gclk_rises - r0, exp_pulses);
        check("toggle_min_width", 32'(min_w), 32'd30);

        // Enable pulse confined to the clk-low phase
        r0 = gclk_rises;
        repeat (3) begin
            @(negedge clk);
            #5;
            in_r = 1'b1;
            d0   = ~m_q0;
            d1   = ~m_q1;
            #10;
            in_r = 1'b0;
            @(posedge clk);
            expect_q();
            #1;
            pop_check("low_pulse");
        end
        check("low_pulse_no_pulses", gclk_rises, r0);

        // Reset asserted mid-high-phase
        cycle(1'b1, 4'h5, 4'hA, "pre_rst");
        @(negedge clk);
        #5;
        in_r = 1'b1;
        d0   = 4'h3;
        d1   = 4'hC;
        @(posedge clk);
        m_q0 = d0;
        m_q1 = d1;
        expect_q();
        #1;
        pop_check("pre_rst_cap");
        #9;
        rst_n = 1'b0;
        m_q0  = '0;
        m_q1  = '0;
        #1;
        check("midrst_gclk", 32'(dut.gclk), 32'd0);
        check("midrst_q0", 32'(q0), 32'd0);
        check("midrst_q1", 32'(q1), 32'd0);
        r0 = gclk_rises;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("midrst_hold_gclk", 32'(dut.gclk), 32'd0);
        check("midrst_hold_pulses", gclk_rises, r0);
        expect_q();
        pop_check("midrst_hold");
        @(negedge clk);
        #10;
        rst_n = 1'b1;
        cycle(1'b1, 4'h9, 4'h6, "post_rst");
        cycle(1'b0, 4'h1, 4'h2, "post_rst_gated");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
